// File: rtl/ucsbece154_dmem_sched.sv
// rtl/ucsbece154_dmem_sched.sv - maps two memory-issue slots onto a dual-port dmem, resolving same-word hazards
module ucsbece154_dmem_sched #(
    parameter logic [31:0] DATA_START = 32'h10000000,
    parameter int          DATA_SIZE  = 64,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             req0_valid_i,
    input  logic             req1_valid_i,
    input  logic             req0_we_i,
    input  logic             req1_we_i,
    input  logic [31:0]      req0_addr_i,
    input  logic [31:0]      req1_addr_i,
    input  logic [31:0]      req0_wdata_i,
    input  logic [31:0]      req1_wdata_i,
    output logic [31:0]      rd0_o,
    output logic [31:0]      rd1_o,
    output logic             stall_o,
    output logic             dm_we_o,
    output logic             dm_we2_o,
    output logic [31:0]      dm_a_o,
    output logic [31:0]      dm_a2_o,
    output logic [31:0]      dm_wd_o,
    output logic [31:0]      dm_wd2_o,
    input  logic [31:0]      dm_rd_i,
    input  logic [31:0]      dm_rd2_i,
    output logic             err_o,
    output logic [CNT_W-1:0] split_cnt_o
);

    typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

    state_t state, state_next;
    logic   v0, v1, legal0, legal1, same, raw, waw, ill0, ill1;

    function automatic logic legal_store(input logic [31:0] a);
        logic [31:0] off;
        off = a - DATA_START;
        return (a[1:0] == 2'b00) && (a >= DATA_START) && (off < 32'(4 * DATA_SIZE));
    endfunction

    // flush masks both slots for the current cycle, so no write, hazard or error can arise
    assign v0     = req0_valid_i & ~flush_i;
    assign v1     = req1_valid_i & ~flush_i;
    assign legal0 = legal_store(req0_addr_i);
    assign legal1 = legal_store(req1_addr_i);
    assign same   = v0 & v1 & (req0_addr_i[31:2] == req1_addr_i[31:2]);
    assign raw    = same & req0_we_i & ~req1_we_i;
    assign waw    = same & req0_we_i & req1_we_i;
    assign ill0   = v0 & req0_we_i & ~legal0;
    assign ill1   = v1 & req1_we_i & ~legal1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (raw) state_next = SPLIT;
            SPLIT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dm_a_o   = req0_addr_i;
        dm_a2_o  = req1_addr_i;
        dm_wd_o  = req0_wdata_i;
        dm_wd2_o = req1_wdata_i;
        dm_we_o  = 1'b0;
        dm_we2_o = 1'b0;
        rd0_o    = 32'h0;
        rd1_o    = 32'h0;
        stall_o  = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    dm_we_o  = v0 & req0_we_i & legal0 & ~waw;
                    dm_we2_o = v1 & req1_we_i & legal1;
                    stall_o  = raw;
                    if (v0 && !req0_we_i)         rd0_o = dm_rd_i;
                    if (v1 && !req1_we_i && !raw) rd1_o = dm_rd2_i;
                end
                SPLIT: begin
                    // the store went out in the previous cycle; only the younger load remains
                    if (!flush_i) rd1_o = dm_rd2_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_o       <= 1'b0;
            split_cnt_o <= '0;
        end else if (state == IDLE) begin
            if (ill0 || ill1) err_o <= 1'b1;
            if (raw && split_cnt_o != '1)
                split_cnt_o <= split_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_ucsbece154_dmem_sched.sv
// tb/tb_ucsbece154_dmem_sched.sv - randomized check of the dmem scheduler against a transaction-level model
module tb_ucsbece154_dmem_sched;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset, flush_i;
    logic             req0_valid_i, req1_valid_i, req0_we_i, req1_we_i;
    logic [31:0]      req0_addr_i, req1_addr_i, req0_wdata_i, req1_wdata_i;
    logic [31:0]      rd0_o, rd1_o;
    logic             stall_o, dm_we_o, dm_we2_o;
    logic [31:0]      dm_a_o, dm_a2_o, dm_wd_o, dm_wd2_o;
    logic [31:0]      dm_rd_i, dm_rd2_i;
    logic             err_o;
    logic [CNT_W-1:0] split_cnt_o;

    ucsbece154_dmem_sched #(.DATA_START(32'h10000000), .DATA_SIZE(64), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .req0_valid_i(req0_valid_i), .req1_valid_i(req1_valid_i),
        .req0_we_i(req0_we_i), .req1_we_i(req1_we_i),
        .req0_addr_i(req0_addr_i), .req1_addr_i(req1_addr_i),
        .req0_wdata_i(req0_wdata_i), .req1_wdata_i(req1_wdata_i),
        .rd0_o(rd0_o), .rd1_o(rd1_o), .stall_o(stall_o),
        .dm_we_o(dm_we_o), .dm_we2_o(dm_we2_o),
        .dm_a_o(dm_a_o), .dm_a2_o(dm_a2_o),
        .dm_wd_o(dm_wd_o), .dm_wd2_o(dm_wd2_o),
        .dm_rd_i(dm_rd_i), .dm_rd2_i(dm_rd2_i),
        .err_o(err_o), .split_cnt_o(split_cnt_o)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        ref_err;
    int          ref_cnt;
    int          total = 0;
    int          bad = 0;

    function automatic bit in_rng(input logic [31:0] a);
        return (a - 32'h10000000) < 32'd256;
    endfunction

    function automatic bit legal_st(input logic [31:0] a);
        return (a[1:0] == 2'b00) && in_rng(a);
    endfunction

    function automatic logic [31:0] junk(input logic [31:0] a);
        return {a[15:0], 16'hBAD0};
    endfunction

    function logic [31:0] ref_rd(input logic [31:0] a);
        return in_rng(a) ? ref_mem[a[7:2]] : junk(a);
    endfunction

    always_comb begin
        dm_rd_i  = in_rng(dm_a_o)  ? mem[dm_a_o[7:2]]  : junk(dm_a_o);
        dm_rd2_i = in_rng(dm_a2_o) ? mem[dm_a2_o[7:2]] : junk(dm_a2_o);
    end

    always @(posedge clk) begin
        if (dm_we_o && in_rng(dm_a_o))   mem[dm_a_o[7:2]]  <= dm_wd_o;
        if (dm_we2_o && in_rng(dm_a2_o)) mem[dm_a2_o[7:2]] <= dm_wd2_o;
    end

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v0, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                         input bit v1, input bit we1, input logic [31:0] a1, input logic [31:0] d1);
        req0_valid_i = v0; req0_we_i = we0; req0_addr_i = a0; req0_wdata_i = d0;
        req1_valid_i = v1; req1_we_i = we1; req1_addr_i = a1; req1_wdata_i = d1;
    endtask

    // One issue group: expectations come from the hazard rules applied to the model memory.
    task automatic txn(input bit v0, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                       input bit v1, input bit we1, input logic [31:0] a1, input logic [31:0] d1,
                       input bit fa, input bit fb);
        bit e0, e1, same, raw, waw, ew, ew2;
        logic [31:0] x0, x1;
        drive(v0, we0, a0, d0, v1, we1, a1, d1);
        flush_i = fa;
        #2;
        e0   = v0 && !fa;
        e1   = v1 && !fa;
        same = e0 && e1 && (a0[31:2] == a1[31:2]);
        raw  = same && we0 && !we1;
        waw  = same && we0 && we1;
        ew   = e0 && we0 && legal_st(a0) && !waw;
        ew2  = e1 && we1 && legal_st(a1);
        x0   = (e0 && !we0) ? ref_rd(a0) : 32'h0;
        x1   = (e1 && !we1 && !raw) ? ref_rd(a1) : 32'h0;
        check32("stall", 32'(stall_o), 32'(raw));
        check32("we", 32'(dm_we_o), 32'(ew));
        check32("we2", 32'(dm_we2_o), 32'(ew2));
        check32("rd0", rd0_o, x0);
        check32("rd1", rd1_o, x1);
        if (ew)  check32("wd", dm_wd_o, d0);
        if (ew2) check32("wd2", dm_wd2_o, d1);
        @(posedge clk); #1;
        if (ew)  ref_mem[a0[7:2]] = d0;
        if (ew2) ref_mem[a1[7:2]] = d1;
        if ((e0 && we0 && !legal_st(a0)) || (e1 && we1 && !legal_st(a1))) ref_err = 1'b1;
        if (raw && ref_cnt < (1 << CNT_W) - 1) ref_cnt++;
        if (raw) begin
            flush_i = fb;
            #1;
            check32("b_stall", 32'(stall_o), 32'h0);
            check32("b_we", 32'(dm_we_o), 32'h0);
            check32("b_we2", 32'(dm_we2_o), 32'h0);
            check32("b_rd0", rd0_o, 32'h0);
            if (!fb) check32("b_rd1", rd1_o, ref_rd(a1));
            @(posedge clk); #1;
        end
        flush_i = 1'b0;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        check32("err", 32'(err_o), 32'(ref_err));
        check32("cnt", 32'(split_cnt_o), 32'(ref_cnt));
        if (in_rng(a0)) check32("mem0", mem[a0[7:2]], ref_mem[a0[7:2]]);
        if (in_rng(a1)) check32("mem1", mem[a1[7:2]], ref_mem[a1[7:2]]);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)  return 32'h10000000 + 32'(4 * $urandom_range(0, 3));
        if (r == 7) return 32'h10000000 + 32'($urandom_range(1, 3));
        if (r == 8) return 32'h20000000;
        return 32'h10000100;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[1] = 32'h55; ref_mem[1] = 32'h55;
        ref_err = 1'b0;
        ref_cnt = 0;

        // reset with a RAW pair presented: all enables and read data must stay low
        reset = 1'b1; flush_i = 1'b0;
        drive(1, 1, 32'h1000000C, 32'h1, 1, 0, 32'h1000000C, 32'h0);
        @(posedge clk); #2;
        check32("rst_we", 32'(dm_we_o), 32'h0);
        check32("rst_we2", 32'(dm_we2_o), 32'h0);
        check32("rst_stall", 32'(stall_o), 32'h0);
        check32("rst_rd1", rd1_o, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        #1;
        check32("rst_err", 32'(err_o), 32'h0);
        check32("rst_cnt", 32'(split_cnt_o), 32'h0);

        txn(1, 1, 32'h10000000, 32'hAAAA, 1, 0, 32'h10000004, 32'h0, 0, 0);
        check32("indep_mem", mem[0], 32'hAAAA);
        txn(1, 1, 32'h10000008, 32'h1, 1, 1, 32'h10000008, 32'h2, 0, 0);
        check32("waw_mem", mem[2], 32'h2);
        txn(1, 1, 32'h1000000C, 32'hBEEF, 1, 0, 32'h1000000C, 32'h0, 0, 0);
        check32("raw_cnt", 32'(split_cnt_o), 32'h1);
        txn(1, 1, 32'h10000010, 32'hBEEF, 1, 0, 32'h10000010, 32'h0, 0, 1);
        check32("flush_mem", mem[4], 32'hBEEF);
        txn(1, 1, 32'h10000002, 32'h5, 0, 0, 32'h0, 32'h0, 0, 0);
        check32("ill_err", 32'(err_o), 32'h1);
        txn(1, 1, 32'h20000000, 32'h6, 0, 0, 32'h0, 32'h0, 0, 0);
        for (int k = 0; k < 3; k++)
            txn(1, 1, 32'h10000014, 32'(k), 1, 0, 32'h10000014, 32'h0, 0, 0);
        check32("sat_cnt", 32'(split_cnt_o), 32'h3);

        // reset during the second cycle of a split: the committed store stands, counters clear
        drive(1, 1, 32'h10000018, 32'h7777, 1, 0, 32'h10000018, 32'h0);
        #2;
        @(posedge clk); #1;
        ref_mem[6] = 32'h7777;
        reset = 1'b1;
        #1;
        check32("rsplit_we2", 32'(dm_we2_o), 32'h0);
        check32("rsplit_rd1", rd1_o, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        ref_err = 1'b0;
        ref_cnt = 0;
        #1;
        check32("rsplit_stall", 32'(stall_o), 32'h0);
        check32("rsplit_err", 32'(err_o), 32'h0);
        check32("rsplit_cnt", 32'(split_cnt_o), 32'h0);
        check32("rsplit_mem", mem[6], 32'h7777);

        for (int n = 0; n < 400; n++)
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
